flatten_stream: RTL and testbench

FLATTEN_STREAM -- requirements
Module: flatten_stream

---
 rtl/flatten_stream_if.sv | 27 ++
 rtl/flatten_stream.sv | 163 ++++++++++++++++
 tb/tb_flatten_stream.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flatten_stream_if.sv
// flatten_stream_if: groups the layer-2 memory read port and the output stream.
//   crd/caddr_rd/csel : read strobe, address and bank select (design -> memory)
//   cdata_rd          : read data, valid the cycle after crd (memory -> design)
//   out_valid/out_ready/out_data/out_last/out_index : output stream handshake
interface flatten_stream_if #(
   parameter int unsigned DW = 20
);
   logic          crd;
   logic [11:0]   caddr_rd;
   logic [DW-1:0] cdata_rd;
   logic [2:0]    csel;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic [10:0]   out_index;

   modport master (
      output crd, caddr_rd, csel, out_valid, out_data, out_last, out_index,
      input  cdata_rd, out_ready
   );

   modport slave (
      input  crd, caddr_rd, csel, out_valid, out_data, out_last, out_index,
      output cdata_rd, out_ready
   );
endinterface

// File: rtl/flatten_stream.sv
// flatten_stream: after a start pulse, reads DEPTH words from the layer-2
// memory in ascending address order and streams them out through a 2-entry
// FIFO with valid/ready flow control.
//   clk, reset (sync, active-low), start (pulse)
//   busy : high from the cycle after an accepted start through the done cycle
//   done : one-cycle pulse after the final handshake
//   bus  : memory read port and output stream (flatten_stream_if.master)
module flatten_stream #(
   parameter int unsigned DEPTH = 2048,
   parameter int unsigned DW    = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   flatten_stream_if.master bus
);

   localparam int unsigned AW = 12;
   localparam int unsigned IW = 11;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] issued_q, issued_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [1:0]    count_q, count_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic          wr_ptr_q, wr_ptr_d;
   logic          inflight_q;
   logic [DW-1:0] fifo0_q, fifo1_q;

   logic crd_c;
   logic pop_c;
   logic push_c;
   logic last_c;

   // Handshake and read-issue decisions; a read is allowed only when the
   // word it returns is guaranteed a FIFO slot (accounting for this cycle's pop).
   always_comb begin
      pop_c  = (count_q != 2'd0) && bus.out_ready;
      push_c = inflight_q;
      last_c = (idx_q == LAST_IDX);
      crd_c  = (state_q == S_RUN) && (issued_q < CW'(DEPTH)) &&
               (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_c}));
   end

   // Next-state, address/index counters and FIFO pointer bookkeeping.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      issued_d = issued_q;
      idx_d    = idx_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;

      // Address saturates at the last word so it never leaves the map.
      if (crd_c) begin
         issued_d = issued_q + CW'(1);
         if (addr_q != LAST_ADDR) begin
            addr_d = addr_q + AW'(1);
         end
      end

      if (pop_c) begin
         rd_ptr_d = ~rd_ptr_q;
         if (!last_c) begin
            idx_d = idx_q + IW'(1);
         end
      end

      if (push_c) begin
         wr_ptr_d = ~wr_ptr_q;
      end

      unique case ({push_c, pop_c})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (crd_c && (issued_q == CW'(DEPTH - 1))) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop_c && last_c) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Stream finished and FIFO empty: rearm counters for the next start.
            state_d  = S_IDLE;
            addr_d   = '0;
            issued_d = '0;
            idx_d    = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         issued_q   <= '0;
         idx_q      <= '0;
         count_q    <= '0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         inflight_q <= 1'b0;
         fifo0_q    <= '0;
         fifo1_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         issued_q   <= issued_d;
         idx_q      <= idx_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         inflight_q <= crd_c;
         if (push_c) begin
            if (wr_ptr_q) begin
               fifo1_q <= bus.cdata_rd;
            end else begin
               fifo0_q <= bus.cdata_rd;
            end
         end
      end
   end

   // Output decode; out_data is a mux of FIFO registers only.
   assign bus.crd       = crd_c;
   assign bus.caddr_rd  = addr_q;
   assign bus.csel      = 3'b101;
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out_data  = rd_ptr_q ? fifo1_q : fifo0_q;
   assign bus.out_index = idx_q;
   assign bus.out_last  = (count_q != 2'd0) && last_c;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_flatten_stream.sv
// tb_flatten_stream: directed tests for flatten_stream with a scoreboard
// queue of expected stream words and a decoupled negedge monitor.
module tb_flatten_stream;
   localparam int unsigned DEPTH = 2048;
   localparam int unsigned DW    = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic start;
   logic busy;
   logic done;
   logic rand_mode;
   logic rdy_fixed;
   logic rnd_bit = 1'b0;
   logic [DW-1:0] mem [DEPTH];

   flatten_stream_if #(.DW(DW)) bus ();

   flatten_stream #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   assign bus.out_ready = rand_mode ? rnd_bit : rdy_fixed;

   // Synchronous memory model: data valid the cycle after crd.
   always @(posedge clk) begin
      if (bus.crd) bus.cdata_rd <= mem[bus.caddr_rd[10:0]];
   end

   always @(posedge clk) begin
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end

   typedef logic [31:0] word_t;
   word_t exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int reads    = 0;
   int acc      = 0;
   int done_cnt = 0;
   logic  stall_prev = 1'b0;
   word_t held = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic word_t obs();
      return {bus.out_last, bus.out_index, bus.out_data};
   endfunction

   // Monitor: pops the scoreboard on each handshake, checks stall stability
   // and that no more than two words are ever outstanding.
   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         reads      = 0;
         acc        = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) chk("stall_hold", obs(), held);
         if (done) done_cnt++;
         if (bus.out_valid && bus.out_ready) begin
            acc++;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_word: got %0h, none expected at %0t", obs(), $time);
            end else begin
               chk("word", obs(), exp_q.pop_front());
            end
         end
         if (bus.crd) begin
            reads++;
            chk("occupancy_le2", 32'(reads - acc <= 2), 32'd1);
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         held       = obs();
      end
   end

   task automatic push_stream();
      for (int i = 0; i < int'(DEPTH); i++) begin
         exp_q.push_back({(i == int'(DEPTH) - 1), 11'(i), mem[i]});
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (!done && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk("done_seen", 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_index(input int idx, input int budget);
      int k;
      k = 0;
      while (!(bus.out_valid && int'(bus.out_index) == idx) && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk("reach_index", 32'(bus.out_index), 32'(idx));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      int last_k;
      int n_rd;
      int a0;
      int a1;
      int d0;
      reset     = 1'b0;
      start     = 1'b0;
      rand_mode = 1'b0;
      rdy_fixed = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i + 5);

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_crd",       32'(bus.crd),       32'd0);
      chk("rst_busy",      32'(busy),          32'd0);
      chk("rst_done",      32'(done),          32'd0);
      chk("rst_valid",     32'(bus.out_valid), 32'd0);
      chk("rst_addr",      32'(bus.caddr_rd),  32'd0);
      chk("rst_index",     32'(bus.out_index), 32'd0);
      chk("rst_last",      32'(bus.out_last),  32'd0);
      chk("rst_data",      32'(bus.out_data),  32'd0);
      chk("rst_csel",      32'(bus.csel),      32'd5);
      reset = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // Full-throughput stream: latency and total cycle count
      push_stream();
      pulse_start();
      chk("lat_crd_n1",   32'(bus.crd),      32'd1);
      chk("lat_addr_n1",  32'(bus.caddr_rd), 32'd0);
      chk("busy_on",      32'(busy),         32'd1);
      @(posedge clk); #1;
      chk("lat_valid_n2", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_valid_n3", 32'(bus.out_valid), 32'd1);
      chk("first_word",   32'(bus.out_data),  32'd5);
      k = 3;
      last_k = 0;
      while (!done && k < 3000) begin
         if (bus.out_valid && bus.out_last) begin
            last_k = k;
            chk("last_data",      32'(bus.out_data), 32'd2052);
            chk("addr_saturated", 32'(bus.caddr_rd), 32'd2047);
         end
         @(posedge clk); #1;
         k++;
      end
      chk("last_cycle", 32'(last_k), 32'd2050);
      chk("done_cycle", 32'(k),      32'd2051);
      chk("busy_in_done", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk("busy_off",   32'(busy),   32'd0);
      chk("done_pulse", 32'(done),   32'd0);
      chk("sb_empty_a", 32'(exp_q.size()), 32'd0);

      // Random back-pressure
      push_stream();
      rand_mode = 1'b1;
      pulse_start();
      wait_done(20000);
      rand_mode = 1'b0;
      chk("sb_empty_b", 32'(exp_q.size()), 32'd0);

      // Stalled start: only two reads may be issued
      push_stream();
      rdy_fixed = 1'b0;
      pulse_start();
      n_rd = 0; a0 = -1; a1 = -1;
      for (int i = 0; i < 20; i++) begin
         if (bus.crd) begin
            if (n_rd == 0) a0 = int'(bus.caddr_rd);
            if (n_rd == 1) a1 = int'(bus.caddr_rd);
            n_rd++;
         end
         @(posedge clk); #1;
      end
      chk("stall_reads", 32'(n_rd), 32'd2);
      chk("stall_addr0", 32'(a0),   32'd0);
      chk("stall_addr1", 32'(a1),   32'd1);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      rdy_fixed = 1'b1;
      #1;
      chk("resume_crd",  32'(bus.crd),      32'd1);
      chk("resume_addr", 32'(bus.caddr_rd), 32'd2);
      wait_done(3000);
      chk("sb_empty_c", 32'(exp_q.size()), 32'd0);

      // Start re-pulsed mid-stream is ignored
      push_stream();
      d0 = done_cnt;
      pulse_start();
      wait_index(100, 500);
      pulse_start();
      chk("restart_busy", 32'(busy), 32'd1);
      wait_done(3000);
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", 32'(done_cnt - d0), 32'd1);
      chk("sb_empty_d", 32'(exp_q.size()), 32'd0);

      // Reset mid-stream, reset-over-start, then fresh stream with max data
      push_stream();
      pulse_start();
      wait_index(500, 1000);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_crd",   32'(bus.crd),       32'd0);
      chk("mid_rst_busy",  32'(busy),          32'd0);
      chk("mid_rst_addr",  32'(bus.caddr_rd),  32'd0);
      chk("mid_rst_index", 32'(bus.out_index), 32'd0);
      chk("mid_rst_csel",  32'(bus.csel),      32'd5);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("rst_over_start", 32'(busy), 32'd0);
      reset = 1'b1;
      mem[DEPTH-1] = 20'hFFFFF;
      @(posedge clk); #1;
      chk("idle_after_rst", 32'(busy), 32'd0);
      push_stream();
      pulse_start();
      k = 0;
      while (!(bus.out_valid && bus.out_last) && k < 3000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("max_last_data",  32'(bus.out_data),  32'hFFFFF);
      chk("max_last_index", 32'(bus.out_index), 32'd2047);
      chk("max_last_flag",  32'(bus.out_last),  32'd1);
      @(posedge clk); #1;
      chk("max_done",      32'(done), 32'd1);
      @(posedge clk); #1;
      chk("max_busy_off",  32'(busy), 32'd0);
      chk("max_done_off",  32'(done), 32'd0);
      chk("sb_empty_e", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
